// File: rtl/seven_segment_pkg.sv
// Shared types and helpers for the seven-segment display path: scanner states,
// digit geometry and the leading-zero blanking mask.
package seven_segment_pkg;

  localparam int DIGIT_WIDTH = 4;
  localparam int MAX_DIGITS  = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  // Bit i (i >= 1) clears when nibbles i..count-1 are all zero; bit 0 always lit.
  function automatic logic [MAX_DIGITS-1:0] leading_zero_mask(
    input logic [DIGIT_WIDTH*MAX_DIGITS-1:0] value,
    input int unsigned                       count
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  seen;
    mask    = '0;
    mask[0] = 1'b1;
    seen    = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < int'(count)) begin
        seen    = seen | (value[DIGIT_WIDTH*i +: DIGIT_WIDTH] != '0);
        mask[i] = seen;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle of the digit scanner: frame inputs from the system and
// the anode / nibble drive toward the display and segment encoder.
interface seven_segment_scanner_if #(
  parameter int DIGIT_COUNT = 4
);
  import seven_segment_pkg::*;

  localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  logic [DIGIT_WIDTH*DIGIT_COUNT-1:0] displayValue;
  logic [DIGIT_COUNT-1:0]             digitEnable;
  logic                               suppressLeadingZeros;
  logic [DIGIT_WIDTH-1:0]             encoderValue;
  logic [DIGIT_COUNT-1:0]             anodeEnableN;
  logic [IDX_W-1:0]                   digitIndex;
  logic                               frameStart;

  modport master (
    output displayValue, digitEnable, suppressLeadingZeros,
    input  encoderValue, anodeEnableN, digitIndex, frameStart
  );

  modport slave (
    input  displayValue, digitEnable, suppressLeadingZeros,
    output encoderValue, anodeEnableN, digitIndex, frameStart
  );

endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode digit scanner: latches a frame, then walks each
// digit through a blanking gap and a drive dwell. All outputs come from flops.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGIT_COUNT  = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  seven_segment_scanner_if.slave  bus
);

  localparam int IDX_W  = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
  localparam int MAX_C  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int VAL_W  = DIGIT_WIDTH * DIGIT_COUNT;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGIT_COUNT - 1);

  scan_state_e            state_q,       state_d;
  logic [CNT_W-1:0]       cnt_q,         cnt_d;
  logic [IDX_W-1:0]       idx_q,         idx_d;
  logic [VAL_W-1:0]       shadow_q,      shadow_d;
  logic [DIGIT_COUNT-1:0] mask_q,        mask_d;
  logic                   frame_start_q, frame_start_d;
  logic [DIGIT_COUNT-1:0] anode_q,       anode_d;
  logic [DIGIT_WIDTH-1:0] encoder_q,     encoder_d;
  logic [IDX_W-1:0]       index_out_q,   index_out_d;
  logic [DIGIT_COUNT-1:0] lz_mask;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    encoder_d     = encoder_q;
    frame_start_d = 1'b0;
    anode_d       = '1;
    index_out_d   = idx_q;
    lz_mask       = DIGIT_COUNT'(leading_zero_mask(
                      (DIGIT_WIDTH*MAX_DIGITS)'(bus.displayValue), DIGIT_COUNT));

    unique case (state_q)
      LOAD: begin
        frame_start_d = 1'b1;
        shadow_d      = bus.displayValue;
        mask_d        = bus.digitEnable & (bus.suppressLeadingZeros ? lz_mask : '1);
        idx_d         = '0;
        index_out_d   = '0;
        cnt_d         = '0;
        state_d       = BLANK;
      end
      BLANK: begin
        // Nibble switches only while the anodes are dark, so it is settled before DRIVE.
        if (cnt_q == '0) encoder_d = shadow_q[{idx_q, 2'b00} +: DIGIT_WIDTH];
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        anode_d[idx_q] = ~mask_q[idx_q];
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = LOAD;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = BLANK;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      mask_q        <= '0;
      frame_start_q <= 1'b0;
      anode_q       <= '1;
      encoder_q     <= '0;
      index_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      frame_start_q <= frame_start_d;
      anode_q       <= anode_d;
      encoder_q     <= encoder_d;
      index_out_q   <= index_out_d;
    end
  end

  assign bus.frameStart   = frame_start_q;
  assign bus.anodeEnableN = anode_q;
  assign bus.encoderValue = encoder_q;
  assign bus.digitIndex   = index_out_q;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexed digit scanner for common-anode multi-digit seven-segment displays.
- Latches a packed multi-digit hex value once per frame and walks a digit index through the digits.
- Drives the active-low digit anodes and presents the current digit's 4-bit nibble to the downstream hex seven-segment encoder.
- Inserts blanking dead time between digits to prevent ghosting, and optionally suppresses leading zeros.

Parameters:
- DIGIT_COUNT, 4, number of digits scanned; legal range 1..8.
- DWELL_CYCLES, 100000, clock cycles each digit's anode is driven; must be >= 1.
- BLANK_CYCLES, 1000, clock cycles all anodes are off before each digit; must be >= 1.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- displayValue  input  4*DIGIT_COUNT  packed nibbles; digit i = bits [4i+3:4i]; digit 0 is least significant.
- digitEnable  input  DIGIT_COUNT  per-digit enable; 0 = digit always dark.
- suppressLeadingZeros  input  1  1 = blank zero-valued digits above the highest nonzero digit.
- encoderValue  output  4  nibble of the current digit; feeds the encoder's value input.
- anodeEnableN  output  DIGIT_COUNT  active-low anode drive; at most one bit low at any time.
- digitIndex  output  clog2(DIGIT_COUNT), min 1  index of the current digit.
- frameStart  output  1  one-cycle pulse in the LOAD cycle.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = LOAD; dwell counter = 0; digitIndex = 0.
  - anodeEnableN = all ones; encoderValue = 0; frameStart = 0.
  - Shadow value = 0; effective mask = 0.
- State machine: LOAD -> BLANK -> DRIVE.
- LOAD (exactly 1 cycle):
  - frameStart = 1.
  - Shadow captures displayValue.
  - Effective mask captures digitEnable AND the leading-zero mask.
  - digitIndex = 0.
  - Next state is BLANK.
- Leading-zero mask:
  - When suppressLeadingZeros = 0, the mask is all ones.
  - When it is 1, bit i (i >= 1) is 0 iff nibbles i..DIGIT_COUNT-1 of displayValue are all zero.
  - Bit 0 is always 1, so a value of zero still shows "0".
- BLANK (BLANK_CYCLES cycles):
  - anodeEnableN = all ones.
  - encoderValue updates to shadow nibble[digitIndex] on the first BLANK cycle.
  - encoderValue is then stable through the following DRIVE.
- DRIVE (DWELL_CYCLES cycles):
  - anodeEnableN[digitIndex] = ~effectiveMask[digitIndex]; all other bits are 1.
- End of DRIVE:
  - If digitIndex == DIGIT_COUNT-1: go to LOAD (wrap).
  - Otherwise: digitIndex += 1, go to BLANK.
- All outputs are registered; no combinational path from any input to any output.
- Frame period = 1 + DIGIT_COUNT*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Input changes outside LOAD have no effect until the next LOAD, so frames are atomic.
- Counter width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)); the counter resets to 0 at every state change.
- DIGIT_COUNT = 1: digitIndex stays 0; each frame is LOAD, BLANK, DRIVE.
- Reset asserted mid-DRIVE: anodes go all-high immediately (asynchronously). After reset deassertion the first cycle is LOAD.
- Invariant: anodeEnableN is all ones in every LOAD and BLANK cycle. It is never low on two bits at once.

Decomposition:
- Shared package seven_segment_pkg holds:
  - scanner state enum (LOAD, BLANK, DRIVE);
  - DIGIT_WIDTH = 4;
  - a function computing the leading-zero mask from a packed value and a digit count.
- The same package is the natural home for the segment index/mask constants used by the encoder.
- No sub-module: counter and FSM are a single block.
- The top level instantiates the scanner and feeds encoderValue into the encoder.

Test Plan:
Bench parameters: DIGIT_COUNT=4, DWELL_CYCLES=4, BLANK_CYCLES=2; frame period = 25 cycles.
1. Release reset, displayValue=16'h1234, digitEnable=4'hF, suppress=0 -> frameStart pulses at cycle 0. Then anodeEnableN = 1111 ×2, 1110 ×4 (encoderValue=4), 1111 ×2, 1101 ×4 (3), 1111 ×2, 1011 ×4 (2), 1111 ×2, 0111 ×4 (1). Next frameStart falls 25 cycles after the first.
2. Change displayValue to 16'hABCD mid-frame -> current frame still shows 4,3,2,1; the next frame shows D,C,B,A.
3. displayValue=16'h0050, suppress=1 -> digits 0 and 1 drive (nibbles 0, 5); anodeEnableN stays 1111 during DRIVE of digits 2 and 3. displayValue=0 with suppress=1 -> only digit 0 lights with encoderValue=0.
4. digitEnable=4'b0101 -> only anodes 0 and 2 ever go low; timing is identical to scenario 1.
5. Assert reset during DRIVE of digit 2 -> anodeEnableN = 1111 immediately and encoderValue = 0. After release, a LOAD with frameStart follows and the scan restarts at digit 0.
6. Run 1000 random frames -> assertion checks that at most one anode is low, that all anodes are high in LOAD/BLANK cycles, and that encoderValue never changes while any anode is low.
